// File: rtl/bounce_pkg.sv
// rtl/bounce_pkg.sv - shared encodings and constants for the switch-bounce emulator
package bounce_pkg;

  typedef enum logic [1:0] {
    ST_STABLE = 2'b00,
    ST_BOUNCE = 2'b01,
    ST_SETTLE = 2'b10
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Longest glitch segment and settle segment for a hold-counter width n
  function automatic int seg_max(input int n);
    return 1 << (n - 1);
  endfunction

  function automatic int settle_len(input int n);
    return 1 << (n + 1);
  endfunction

endpackage

// File: rtl/sw_bounce_gen_lfsr16.sv
// rtl/sw_bounce_gen_lfsr16.sv - free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1
module lfsr16
  import bounce_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= SEED;
    end else begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/sw_bounce_gen.sv
// rtl/sw_bounce_gen.sv - turns a clean level into a bouncing switch waveform on sw
module sw_bounce_gen
  import bounce_pkg::*;
#(
  parameter int          N    = 5,
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic clk,
  input  logic reset_n,
  input  logic lvl_in,
  input  logic bounce_en,
  output logic sw,
  output logic busy,
  output logic done_tick
);

  // 2^(N+1) truncates to zero in N+1 bits; counting down from 0 wraps and still yields 2^(N+1) cycles
  localparam int         SETTLE_LEN = settle_len(N);
  localparam logic [N:0] HCNT_ONE   = {{N{1'b0}}, 1'b1};

  state_t     state_q, state_d;
  logic       cur_q, cur_d;
  logic       tgt_q, tgt_d;
  logic       sw_q, sw_d;
  logic       tick_q, tick_d;
  logic [2:0] gcnt_q, gcnt_d;
  logic [N:0] hcnt_q, hcnt_d;
  logic [N:0] seg_len;
  logic [15:0] lfsr;
  logic       unused_lfsr;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (lfsr)
  );

  assign seg_len     = {2'b00, lfsr[N-2:0]} + HCNT_ONE;
  assign unused_lfsr = ^lfsr[15:N-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STABLE;
      cur_q   <= 1'b0;
      tgt_q   <= 1'b0;
      sw_q    <= 1'b0;
      tick_q  <= 1'b0;
      gcnt_q  <= 3'd0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      sw_q    <= sw_d;
      tick_q  <= tick_d;
      gcnt_q  <= gcnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    sw_d    = sw_q;
    tick_d  = 1'b0;
    gcnt_d  = gcnt_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      ST_STABLE: begin
        sw_d = cur_q;
        if (lvl_in != cur_q) begin
          sw_d = lvl_in;
          if (!bounce_en) begin
            cur_d  = lvl_in;
            tick_d = 1'b1;
          end else begin
            tgt_d   = lvl_in;
            gcnt_d  = lfsr[2:0];
            hcnt_d  = seg_len;
            state_d = ST_BOUNCE;
          end
        end
      end
      ST_BOUNCE: begin
        if (hcnt_q == HCNT_ONE) begin
          hcnt_d = seg_len;
          if (sw_q == tgt_q) begin
            sw_d = ~tgt_q;
          end else if (gcnt_q != 3'd0) begin
            gcnt_d = gcnt_q - 3'd1;
            sw_d   = tgt_q;
          end else begin
            sw_d    = tgt_q;
            hcnt_d  = SETTLE_LEN[N:0];
            state_d = ST_SETTLE;
          end
        end else begin
          hcnt_d = hcnt_q - HCNT_ONE;
        end
      end
      ST_SETTLE: begin
        sw_d = tgt_q;
        if (hcnt_q == HCNT_ONE) begin
          cur_d   = tgt_q;
          state_d = ST_STABLE;
        end else begin
          hcnt_d = hcnt_q - HCNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        sw_d    = cur_q;
      end
    endcase
  end

  assign sw        = sw_q;
  assign busy      = (state_q != ST_STABLE);
  // Bypass tick is registered; the settle tick marks the last SETTLE cycle itself
  assign done_tick = tick_q | ((state_q == ST_SETTLE) && (hcnt_q == HCNT_ONE));

endmodule

// File: tb/tb_sw_bounce_gen.sv
// tb/tb_sw_bounce_gen.sv - scoreboard bench for sw_bounce_gen
module tb_sw_bounce_gen;

  localparam int          N      = 5;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          SETTLE = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic lvl_in = 1'b0;
  logic bounce_en = 1'b0;
  logic sw, busy, done_tick;

  always #5 clk = ~clk;

  sw_bounce_gen #(.N(N), .SEED(SEED)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .lvl_in    (lvl_in),
    .bounce_en (bounce_en),
    .sw        (sw),
    .busy      (busy),
    .done_tick (done_tick)
  );

  typedef struct {
    int   cyc;
    logic val;
  } ev_t;

  ev_t  edge_q[$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bfrom = 1;
  int   bto = 0;
  logic prev_sw = 1'b0;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int seg_len(input logic [15:0] v);
    logic [N-2:0] low;
    low = v[N-2:0];
    return int'(low) + 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= SEED;
    else          m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_edge(input int c, input logic v);
    ev_t ev;
    ev.cyc = c;
    ev.val = v;
    edge_q.push_back(ev);
  endtask

  // Called at a negedge with lvl_in already driven; detection happens at the next posedge
  task automatic expect_transition(input logic tgt, input logic bnc, output int end_c);
    int e, t, h, g;
    logic [15:0] v;
    logic level;
    e = cyc + 1;
    if (!bnc) begin
      push_edge(e, tgt);
      done_q.push_back(e);
      bfrom = 1;
      bto   = 0;
      end_c = e;
    end else begin
      v = m_lfsr;
      g = int'(v[2:0]);
      h = seg_len(v);
      t = e;
      level = tgt;
      push_edge(t, tgt);
      while (1) begin
        for (int i = 0; i < h; i++) v = lfsr_step(v);
        t = t + h;
        if (level == tgt) begin
          level = ~tgt;
          push_edge(t, level);
          h = seg_len(v);
        end else if (g != 0) begin
          g--;
          level = tgt;
          push_edge(t, level);
          h = seg_len(v);
        end else begin
          push_edge(t, tgt);
          break;
        end
      end
      done_q.push_back(t + SETTLE - 1);
      bfrom = e;
      bto   = t + SETTLE - 1;
      end_c = t + SETTLE;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int end_c, input string name);
    wait_until(end_c + 3);
    check({name, "_edges_left"}, edge_q.size(), 0);
    check({name, "_ticks_left"}, done_q.size(), 0);
  endtask

  task automatic clear_expect();
    edge_q.delete();
    done_q.delete();
    bfrom = 1;
    bto   = 0;
  endtask

  // Monitor: pops the scoreboard whenever sw toggles or done_tick fires
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_sw = sw;
    end else begin
      check("busy", int'(busy), int'(cyc >= bfrom && cyc <= bto));
      while (edge_q.size() > 0 && edge_q[0].cyc < cyc) begin
        check("missed_sw_edge", cyc, edge_q[0].cyc);
        void'(edge_q.pop_front());
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
        check("missed_done_tick", cyc, done_q[0]);
        void'(done_q.pop_front());
      end
      if (sw !== prev_sw) begin
        if (edge_q.size() == 0) begin
          check("unexpected_sw_edge", int'(sw), int'(prev_sw));
        end else begin
          ev_t ev;
          ev = edge_q.pop_front();
          check("sw_edge_cycle", cyc, ev.cyc);
          check("sw_edge_level", int'(sw), int'(ev.val));
        end
      end
      if (done_tick === 1'b1) begin
        if (done_q.size() == 0) check("unexpected_done_tick", int'(done_tick), 0);
        else check("done_tick_cycle", cyc, done_q.pop_front());
      end
      prev_sw = sw;
    end
  end

  initial begin
    int ec;
    #1 reset_n = 1'b0;
    lvl_in    = 1'b1;
    bounce_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sw", int'(sw), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done_tick), 0);

    // Release with lvl_in=1 held: bypass transition right after reset
    reset_n = 1'b1;
    expect_transition(1'b1, 1'b0, ec);
    drain(ec, "post_reset");

    lvl_in = 1'b0;
    expect_transition(1'b0, 1'b0, ec);
    drain(ec, "bypass_fall");
    lvl_in = 1'b1;
    expect_transition(1'b1, 1'b0, ec);
    drain(ec, "bypass_rise");

    bounce_en = 1'b1;
    lvl_in = 1'b0;
    expect_transition(1'b0, 1'b1, ec);
    drain(ec, "bounce_fall");
    lvl_in = 1'b1;
    expect_transition(1'b1, 1'b1, ec);
    drain(ec, "bounce_rise");

    // Wiggle lvl_in during a burst but end on the target: nothing extra
    lvl_in = 1'b0;
    expect_transition(1'b0, 1'b1, ec);
    repeat (2) @(negedge clk);
    lvl_in = 1'b1;
    repeat (2) @(negedge clk);
    lvl_in = 1'b0;
    drain(ec, "wiggle");

    // Change held through a burst: picked up on the first STABLE cycle
    lvl_in = 1'b1;
    expect_transition(1'b1, 1'b1, ec);
    repeat (3) @(negedge clk);
    lvl_in = 1'b0;
    wait_until(ec);
    expect_transition(1'b0, 1'b1, ec);
    drain(ec, "held_change");

    // Full reset, then a burst from SEED interrupted by reset, then the same burst again
    #2 reset_n = 1'b0;
    clear_expect();
    lvl_in = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    expect_transition(1'b1, 1'b1, ec);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_sw", int'(sw), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done_tick), 0);
    clear_expect();
    repeat (3) @(negedge clk);
    check("midreset_hold_done", int'(done_tick), 0);
    reset_n = 1'b1;
    expect_transition(1'b1, 1'b1, ec);
    drain(ec, "repeat_burst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
